// File: rtl/fmax_reduce.sv
// Streaming FP32 max reducer: running maximum, argmax position and sticky NaN flag per packet.
// Optional FMAX_ARGMAX_EN implements the index counter/register; otherwise out_idx is tied to 0.
`timescale 1ns/1ps
module fmax_reduce #(
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Fmax_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_nan
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam logic [31:0] CANON_NAN = 32'hFFC00000;

  state_t      state_reg;
  logic [31:0] max_reg;
  logic        nan_reg;
  logic        out_valid_reg;
  logic        accept;
  logic        in_nan;
  logic        greater;

  // Sign-magnitude to unsigned ordering: positives above negatives, negatives reversed.
  function automatic logic [31:0] order_key(input logic [31:0] b);
    return b[31] ? ~b : {1'b1, b[30:0]};
  endfunction

  assign in_ready  = Fmax_en && (state_reg != HOLD);
  assign accept    = in_valid && in_ready;
  assign in_nan    = (in_data[30:23] == 8'hFF) && (in_data[22:0] != 23'd0);
  assign greater   = order_key(in_data) > order_key(max_reg);
  assign out_valid = out_valid_reg;
  assign out_data  = max_reg;
  assign out_nan   = nan_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      max_reg       <= 32'h0;
      nan_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            max_reg       <= in_nan ? CANON_NAN : in_data;
            nan_reg       <= in_nan;
            state_reg     <= in_last ? HOLD : ACCUM;
            out_valid_reg <= in_last;
          end
        end
        ACCUM: begin
          if (accept) begin
            // Once a NaN has been seen the result is frozen at the canonical NaN.
            if (!nan_reg) begin
              if (in_nan) begin
                nan_reg <= 1'b1;
                max_reg <= CANON_NAN;
              end else if (greater) begin
                max_reg <= in_data;
              end
            end
            if (in_last) begin
              state_reg     <= HOLD;
              out_valid_reg <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_reg     <= IDLE;
            max_reg       <= 32'h0;
            nan_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
          end
        end
        default: begin
          state_reg     <= IDLE;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

`ifdef FMAX_ARGMAX_EN
  localparam logic [IDX_W-1:0] CNT_MAX = '1;

  logic [IDX_W-1:0] cnt_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             take;

  // An ACCUM beat claims the index when it is the first NaN or a strict new maximum.
  assign take    = accept && (state_reg == ACCUM) && !nan_reg && (in_nan || greater);
  assign out_idx = idx_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
      idx_reg <= '0;
    end else begin
      if (state_reg == IDLE) begin
        if (accept) begin
          cnt_reg <= IDX_W'(1);
          idx_reg <= '0;
        end
      end else if (state_reg == ACCUM) begin
        if (take)
          idx_reg <= cnt_reg;
        if (accept && (cnt_reg != CNT_MAX))
          cnt_reg <= cnt_reg + IDX_W'(1);
      end else if (out_ready) begin
        cnt_reg <= '0;
        idx_reg <= '0;
      end
    end
  end
`else
  assign out_idx = '0;
`endif

endmodule

// File: tb/tb_fmax_reduce.sv
// Directed testbench for fmax_reduce: hand-computed packets, back-pressure, pause and reset cases.
`timescale 1ns/1ps
module tb_fmax_reduce;

  localparam int IDX_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             Fmax_en;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [IDX_W-1:0] out_idx;
  logic             out_nan;

  int n_cmp = 0;
  int n_bad = 0;

  fmax_reduce #(.IDX_W(IDX_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Fmax_en   (Fmax_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_nan   (out_nan)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  // Without the argmax option the index output is always zero.
  function automatic logic [31:0] exp_idx(input int i);
`ifdef FMAX_ARGMAX_EN
    return 32'(i);
`else
    return 32'(i * 0);
`endif
  endfunction

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic beat(input logic [31:0] d, input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 20) begin
        check("beat_timeout", 32'(in_ready), 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Result must be visible the cycle after the last beat; out_ready is assumed high.
  task automatic expect_result(input string tag, input logic [31:0] d, input int idx,
                               input logic nan);
    @(negedge clk);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"}, out_data, d);
    check({tag, "_idx"}, 32'(out_idx), exp_idx(idx));
    check({tag, "_nan"}, 32'(out_nan), 32'(nan));
    @(posedge clk);
    #1;
    check({tag, "_drained"}, 32'(out_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    Fmax_en   = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #3;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", out_data, 32'h0);
    check("rst_idx", 32'(out_idx), 32'd0);
    check("rst_nan", 32'(out_nan), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic three-beat packet; no result before the last beat.
    beat(32'h3F800000, 1'b0);
    beat(32'hC0000000, 1'b0);
    check("p1_not_early", 32'(out_valid), 32'd0);
    beat(32'h40400000, 1'b1);
    expect_result("p1", 32'h40400000, 2, 1'b0);

    // +0 beats -0; equal values keep the first index.
    beat(32'h80000000, 1'b0);
    beat(32'h00000000, 1'b1);
    expect_result("zero", 32'h00000000, 1, 1'b0);
    beat(32'h40000000, 1'b0);
    beat(32'h40000000, 1'b1);
    expect_result("tie", 32'h40000000, 0, 1'b0);

    // Denormals by magnitude; negatives ordered reversed.
    beat(32'h00000002, 1'b0);
    beat(32'h00000001, 1'b0);
    beat(32'h00000003, 1'b1);
    expect_result("denorm", 32'h00000003, 2, 1'b0);
    beat(32'hBF800000, 1'b0);
    beat(32'hC0000000, 1'b1);
    expect_result("neg", 32'hBF800000, 0, 1'b0);

    // First NaN fixes idx; later +inf does not move it.
    beat(32'hC0000000, 1'b0);
    beat(32'h7FC00001, 1'b0);
    beat(32'h7F800000, 1'b1);
    expect_result("nan", 32'hFFC00000, 1, 1'b1);

    // Single beat with output back-pressure.
    out_ready = 1'b0;
    beat(32'h7F800000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data", out_data, 32'h7F800000);
      check("hold_idx", 32'(out_idx), 32'd0);
      check("hold_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("hold_released", 32'(out_valid), 32'd0);
    check("hold_ready_back", 32'(in_ready), 32'd1);

    // Pause mid-packet with a beat pending on the input.
    beat(32'h40A00000, 1'b0);
    Fmax_en  = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'h41000000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("pause_ready", 32'(in_ready), 32'd0);
    end
    check("pause_no_out", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    Fmax_en  = 1'b1;
    beat(32'h41000000, 1'b0);
    beat(32'h3F800000, 1'b1);
    expect_result("pause", 32'h41000000, 1, 1'b0);

    // Reset after two beats discards the partial result.
    beat(32'h3F800000, 1'b0);
    beat(32'h40000000, 1'b0);
    check("pre_rst_data", out_data, 32'h40000000);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data", out_data, 32'h0);
    check("mid_rst_idx", 32'(out_idx), 32'd0);
    check("mid_rst_nan", 32'(out_nan), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    beat(32'hBF800000, 1'b1);
    expect_result("post_rst", 32'hBF800000, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
